// File: rtl/mem_axi_arbiter.sv
// mem_axi_arbiter: shares one AXI4 master between the instruction-fetch port
// and the load/store port. Each port has at most one single-beat access in
// flight and stalls its pipeline stage until the response returns.
module mem_axi_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {P_IDLE, P_PEND, P_DONE} port_state_t;
  typedef enum logic [1:0] {AR_IDLE, AR_SEND, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_t;

  port_state_t inst_state, data_state;
  rd_state_t   rd_state;
  wr_state_t   wr_state;

  logic        inst_queued, data_queued;
  logic [29:0] inst_word, data_word;
  logic [31:0] data_wdata_q;
  logic [3:0]  data_wen_q;

  logic inst_accept, data_accept, data_is_wr;
  logic r_hs, inst_r_done, data_r_done, b_hs;
  logic aw_done, w_done;

  // Response status and low address bits carry no information here.
  logic unused;
  assign unused = ^{rresp, bresp, bid, inst_addr[1:0], data_addr[1:0]};

  assign inst_accept = (inst_state == P_IDLE) && inst_en;
  assign data_accept = (data_state == P_IDLE) && data_en;
  assign data_is_wr  = (data_wen != 4'd0);

  assign r_hs        = rvalid && rready;
  assign inst_r_done = r_hs && (rid == INST_ID) && (inst_state == P_PEND);
  assign data_r_done = r_hs && (rid == DATA_ID) && (data_state == P_PEND);
  assign b_hs        = bvalid && bready;

  // Stall is high in the acceptance cycle so the stage holds immediately.
  assign inst_stall = inst_accept || (inst_state == P_PEND);
  assign data_stall = data_accept || (data_state == P_PEND);

  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = DATA_ID;
  assign awaddr  = {data_word, 2'b00};
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wdata   = data_wdata_q;
  assign wstrb   = data_wen_q;
  assign wlast   = 1'b1;

  // Request capture: address/wen/wdata stay stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (inst_accept) inst_word <= inst_addr[31:2];
    if (data_accept) begin
      data_word    <= data_addr[31:2];
      data_wen_q   <= data_wen;
      data_wdata_q <= data_wdata;
    end
  end

  // Instruction port FSM; DONE lets the held fetch stage advance once.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_state <= P_IDLE;
      inst_rdata <= 32'd0;
    end else begin
      case (inst_state)
        P_IDLE:  if (inst_en) inst_state <= P_PEND;
        P_PEND:  if (inst_r_done) begin
                   inst_state <= P_DONE;
                   inst_rdata <= rdata;
                 end
        P_DONE:  inst_state <= P_IDLE;
        default: inst_state <= P_IDLE;
      endcase
    end
  end

  // Data port FSM; completes on its R beat (loads) or B response (stores).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_state <= P_IDLE;
      data_rdata <= 32'd0;
    end else begin
      case (data_state)
        P_IDLE:  if (data_en) data_state <= P_PEND;
        P_PEND:  begin
                   if (data_r_done) data_rdata <= rdata;
                   if (data_r_done || b_hs) data_state <= P_DONE;
                 end
        P_DONE:  data_state <= P_IDLE;
        default: data_state <= P_IDLE;
      endcase
    end
  end

  // Shared read channel: one read outstanding, data reads win ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state    <= AR_IDLE;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      arid        <= 4'd0;
      araddr      <= 32'd0;
      inst_queued <= 1'b0;
      data_queued <= 1'b0;
    end else begin
      case (rd_state)
        AR_IDLE: begin
          if (data_queued) begin
            arid        <= DATA_ID;
            araddr      <= {data_word, 2'b00};
            arvalid     <= 1'b1;
            data_queued <= 1'b0;
            rd_state    <= AR_SEND;
          end else if (inst_queued) begin
            arid        <= INST_ID;
            araddr      <= {inst_word, 2'b00};
            arvalid     <= 1'b1;
            inst_queued <= 1'b0;
            rd_state    <= AR_SEND;
          end
        end
        AR_SEND: if (arready) begin
          arvalid  <= 1'b0;
          rready   <= 1'b1;
          rd_state <= R_WAIT;
        end
        R_WAIT: if (rvalid && rlast) begin
          rready   <= 1'b0;
          rd_state <= AR_IDLE;
        end
        default: rd_state <= AR_IDLE;
      endcase
      // A port's queue flag cannot be set and issued in the same cycle.
      if (inst_accept) inst_queued <= 1'b1;
      if (data_accept && !data_is_wr) data_queued <= 1'b1;
    end
  end

  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

  // Write channel: AW and W rise together and retire independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (data_accept && data_is_wr) begin
          awvalid  <= 1'b1;
          wvalid   <= 1'b1;
          wr_state <= W_SEND;
        end
        W_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready   <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          bready   <= 1'b0;
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
